fir_coef_loader: RTL

Coefficient sequencer that drives the coefficient shift-load port (`coef_in`/`load_c`) of the 25-tap FIR filter. A host writes coefficients into a local bank by tap index at any time while idle. On `start`, the block streams the bank into the filter's shift chain in the correct order. It then holds off a filter-output-valid flag until the filter pipeline contains only post-load samples.

---
 rtl/fir_coef_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Coefficient bank and sequencer for the 25-tap FIR shift-load port: stream bank[TAPS-1]..bank[0], then flush.
// Optional build macro FIR_COEF_LOADER_CHECKSUM_EN enables the streamed-coefficient checksum accumulator.
module fir_coef_loader #(
  parameter  int TAPS       = 25,
  parameter  int COEF_WIDTH = 16,
  localparam int ADDR_W     = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [COEF_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic [COEF_WIDTH-1:0] coef_out,
  output logic                  load_c,
  output logic                  busy,
  output logic                  done,
  output logic                  filt_valid,
  output logic                  wr_err,
  output logic [COEF_WIDTH-1:0] checksum
);

  localparam int CNT_W = $clog2(TAPS + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state;
  logic [COEF_WIDTH-1:0] bank [TAPS];
  logic [ADDR_W-1:0]     idx;
  logic [ADDR_W-1:0]     idx_nxt;
  logic [CNT_W-1:0]      fcnt;
  logic                  in_range;
  logic                  wr_ok;
  logic                  wr_bad;
  logic                  go;
  logic [COEF_WIDTH-1:0] first_coef;

  assign in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(TAPS));
  assign wr_ok    = wr_en && (state == IDLE) && in_range;
  assign wr_bad   = wr_en && !wr_ok;
  assign go       = start && (state == IDLE);
  assign idx_nxt  = idx - ADDR_W'(1);

  // A write landing on the last tap in the start cycle must be the first value streamed.
  assign first_coef = (wr_ok && (wr_addr == ADDR_W'(TAPS - 1))) ? wr_data : bank[TAPS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) bank[i] <= '0;
    end else if (wr_ok) begin
      bank[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      fcnt       <= '0;
      coef_out   <= '0;
      load_c     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      filt_valid <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_bad;
      case (state)
        IDLE: begin
          if (go) begin
            state      <= LOAD;
            busy       <= 1'b1;
            load_c     <= 1'b1;
            filt_valid <= 1'b0;
            coef_out   <= first_coef;
            idx        <= ADDR_W'(TAPS - 1);
          end
        end
        LOAD: begin
          if (idx == '0) begin
            state    <= FLUSH;
            load_c   <= 1'b0;
            coef_out <= '0;
            fcnt     <= '0;
          end else begin
            idx      <= idx_nxt;
            coef_out <= bank[idx_nxt];
          end
        end
        FLUSH: begin
          // TAPS data shifts plus the product and output registers of the filter.
          if (fcnt == CNT_W'(TAPS + 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            filt_valid <= 1'b1;
          end else begin
            fcnt <= fcnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (go) begin
      checksum <= '0;
    end else if (state == LOAD) begin
      checksum <= checksum + coef_out;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
